bin_para_bcd: RTL and testbench
===============================

// Module: bin_para_bcd
// PURPOSE
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   Feeds the 7-segment digit decoders: each output digit is a 5-bit code 0..9,
//   wired directly to one decoder's 5-bit digit input.
//   Start/busy/done handshake; the result is held stable between conversions,
//   so the display never shows partial values.
// PARAMETERS
//   WIDTH  14  bit width of the binary input value (2..20)
//   NDIG    4  number of BCD digits produced (1..6)
// PORTS
//   clock    in   1           system clock, rising edge
//   reset_n  in   1           asynchronous, active-low reset
//   valor    in   WIDTH       binary value; sampled only on an accepted start
//   start    in   1           conversion request; level-sampled each edge
//   digitos  out  5*NDIG      digit i in [5*i+4:5*i]; i=0 is units; bit 5*i+4 always 0
//   busy     out  1           1 while a conversion is in progress
//   done     out  1           1-cycle pulse: digitos/overflow just updated
//   overflow out  1           valor of the last completed conversion > 10^NDIG-1
// BEHAVIOUR
// - Reset (async assert, sync release): state OCIOSO; digitos=0, busy=0, done=0,
//   overflow=0; internal shift regs and counter cleared. Mid-conversion reset aborts.
//   No done pulse follows; outputs read 0.
// - States: OCIOSO -> CONVERTE -> OCIOSO. busy = (state==CONVERTE), registered.
// - OCIOSO: start=1 at edge k -> latch valor into a WIDTH-bit shift reg; clear the
//   4*NDIG-bit BCD accumulator; counter=WIDTH; latch ovf = (valor > 10^NDIG-1);
//   go CONVERTE (busy=1 after edge k).
// - CONVERTE, each edge: every 4-bit BCD nibble >=5 gets +3 (all nibbles in parallel,
//   before the shift); then shift {bcd,bin} left 1, MSB of bin enters bcd LSB;
//   counter decrements. Accumulator carry out of the top nibble is discarded.
// - On the WIDTH-th shift (edge k+WIDTH): write digitos from the final accumulator
//   (nibble zero-extended to 5 bits), write overflow=ovf, done=1 for one cycle,
//   return to OCIOSO. Latency: done visible WIDTH clocks after the start edge.
// - start while busy=1: ignored; valor changes while busy have no effect.
// - start=1 in the done cycle (state already OCIOSO): accepted; back-to-back
//   conversions every WIDTH+1 clocks max. A held start restarts each time.
// - digitos/overflow change only in the done cycle; stable otherwise.
// - Arithmetic: without saturation, digitos = valor mod 10^NDIG (truncated top).
// CONFIGURATION
//   BCD_SATURA_EN defined: if ovf, the done-cycle write forces every digit to 9
//     (displays 99..9); overflow still 1.
//   BCD_SATURA_EN undefined: digitos = valor mod 10^NDIG; overflow flags wrap.
//   Latency and handshake are identical either way.
// TESTING (WIDTH=14, NDIG=4)
// 1. reset_n=0 then release; start valor=1234 -> busy at next edge, done exactly
//    14 clocks after start edge, digitos = 1,2,3,4 (thousands..units), overflow=0.
// 2. valor=0 -> 0000; valor=9999 -> 9999, overflow=0; valor=10000 -> overflow=1.
// 3. valor=16383: undefined EN -> digits 6383, overflow=1; with BCD_SATURA_EN ->
//    9999, overflow=1.
// 4. start valor=42, at cycle 5 pulse start with valor=777 -> ignored, result 0042;
//    start valor=777 in the done cycle -> accepted, next done 14 clocks later = 0777.
// 5. reset_n=0 at cycle 7 of a conversion -> all outputs 0 at once; no done pulse.
//    Next conversion of 5 -> 0005, correct.
// 6. Random valor x 1000 vs reference model (mod or saturate per macro); check
//    digitos stable and bit 4 of each digit 0 between done pulses.

Source files
------------

// File: rtl/bin_para_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with start/busy/done handshake.
// Optional feature: define BCD_SATURA_EN to show all nines when the value does not fit in NDIG digits.
`timescale 1ns/1ps

module bin_para_bcd #(
    parameter int WIDTH = 14,
    parameter int NDIG  = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [WIDTH-1:0]    valor,
    input  logic                start,
    output logic [5*NDIG-1:0]   digitos,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int unsigned LIMITE = 10**NDIG - 1;

    typedef enum logic {OCIOSO, CONVERTE} estado_t;

    estado_t             estado;
    logic [WIDTH-1:0]    bin;
    logic [4*NDIG-1:0]   bcd;
    logic [CW-1:0]       cnt;
    logic                ovf;

    logic [4*NDIG-1:0]   bcd_adj;
    logic [4*NDIG-1:0]   bcd_next;
    logic [WIDTH-1:0]    bin_next;
    logic                excede;

    // Add 3 to every nibble >= 5 before the shift; the top nibble's carry falls off,
    // which leaves the accumulator holding valor mod 10^NDIG.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[4*NDIG-2:0], bin[WIDTH-1]};
        bin_next = {bin[WIDTH-2:0], 1'b0};
        excede   = 32'(valor) > LIMITE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado   <= OCIOSO;
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            digitos  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (start) begin
                        bin    <= valor;
                        bcd    <= '0;
                        cnt    <= CW'(WIDTH);
                        ovf    <= excede;
                        estado <= CONVERTE;
                        busy   <= 1'b1;
                    end
                end
                CONVERTE: begin
                    bin <= bin_next;
                    bcd <= bcd_next;
                    cnt <= cnt - 1'b1;
                    // Last shift: publish the result in the same edge so outputs never show partial values.
                    if (cnt == CW'(1)) begin
                        estado   <= OCIOSO;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        overflow <= ovf;
                        for (int i = 0; i < NDIG; i++) begin
`ifdef BCD_SATURA_EN
                            digitos[5*i +: 5] <= ovf ? 5'd9 : {1'b0, bcd_next[4*i +: 4]};
`else
                            digitos[5*i +: 5] <= {1'b0, bcd_next[4*i +: 4]};
`endif
                        end
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_para_bcd.sv
// Self-checking bench for bin_para_bcd (WIDTH=14, NDIG=4); honours BCD_SATURA_EN in its reference model.
`timescale 1ns/1ps

module tb_bin_para_bcd;

    localparam int WIDTH = 14;
    localparam int NDIG  = 4;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [WIDTH-1:0]  valor = '0;
    logic              start = 1'b0;
    logic [5*NDIG-1:0] digitos;
    logic              busy;
    logic              done;
    logic              overflow;

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    bin_para_bcd #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .valor    (valor),
        .start    (start),
        .digitos  (digitos),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    // Expected display contents for a value, straight from decimal arithmetic.
    function automatic logic [19:0] refDig(input int v);
        int r;
        logic [19:0] d;
`ifdef BCD_SATURA_EN
        r = (v > 9999) ? 9999 : v % 10000;
`else
        r = v % 10000;
`endif
        d = '0;
        for (int i = 0; i < NDIG; i++) d[5*i +: 5] = 5'((r / (10**i)) % 10);
        return d;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted start schedules its result WIDTH edges later.
    logic        m_busy, m_done, m_ovf, m_pend_ovf;
    logic [19:0] m_dig, m_pend_dig;
    int          cyc, m_done_cyc;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_ovf  <= 1'b0;
            m_dig  <= '0;
        end else begin
            if (m_busy && cyc == m_done_cyc) begin
                m_dig  <= m_pend_dig;
                m_ovf  <= m_pend_ovf;
                m_done <= 1'b1;
                m_busy <= 1'b0;
            end else begin
                m_done <= 1'b0;
            end
            if (!m_busy && start) begin
                m_busy     <= 1'b1;
                m_done_cyc <= cyc + WIDTH;
                m_pend_dig <= refDig(int'(valor));
                m_pend_ovf <= int'(valor) > 9999;
            end
            cyc <= cyc + 1;
        end
    end

    initial cyc = 0;

    always @(negedge clock) begin
        if (run) begin
            checkOutput("busy", 32'(busy), 32'(m_busy));
            checkOutput("done", 32'(done), 32'(m_done));
            checkOutput("digitos", 32'(digitos), 32'(m_dig));
            checkOutput("overflow", 32'(overflow), 32'(m_ovf));
            for (int i = 0; i < NDIG; i++) checkOutput("digit_bit4", 32'(digitos[5*i+4]), 32'd0);
        end
    end

    // Start one conversion from the current cycle and wait (bounded) for its done pulse.
    task automatic applyStimulus(input int v, input logic [19:0] expDig, input logic expOvf, input string name);
        int lat;
        lat = -1;
        start = 1'b1;
        valor = WIDTH'(v);
        for (int j = 0; j < 40; j++) begin
            @(posedge clock); #1;
            if (j == 0) begin
                start = 1'b0;
                valor = WIDTH'($urandom_range(0, 16383));
                checkOutput({name, "_busy_after_start"}, 32'(busy), 32'd1);
            end
            if (done) begin
                lat = j;
                break;
            end
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'd14);
        checkOutput({name, "_digitos"}, 32'(digitos), 32'(expDig));
        checkOutput({name, "_overflow"}, 32'(overflow), 32'(expOvf));
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_digitos", 32'(digitos), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        run = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        applyStimulus(1234, {5'd1, 5'd2, 5'd3, 5'd4}, 1'b0, "v1234");
        repeat (3) @(posedge clock);
        #1;
        applyStimulus(0, 20'd0, 1'b0, "v0");
        applyStimulus(9999, {5'd9, 5'd9, 5'd9, 5'd9}, 1'b0, "v9999");
`ifdef BCD_SATURA_EN
        applyStimulus(10000, {5'd9, 5'd9, 5'd9, 5'd9}, 1'b1, "v10000");
        applyStimulus(16383, {5'd9, 5'd9, 5'd9, 5'd9}, 1'b1, "v16383");
`else
        applyStimulus(10000, 20'd0, 1'b1, "v10000");
        applyStimulus(16383, {5'd6, 5'd3, 5'd8, 5'd3}, 1'b1, "v16383");
`endif

        // A start while busy must be ignored; a start in the done cycle must be taken.
        start = 1'b1;
        valor = WIDTH'(42);
        lat = -1;
        for (int j = 0; j < 40; j++) begin
            @(posedge clock); #1;
            start = (j == 4);
            if (j == 4) valor = WIDTH'(777);
            if (done) begin
                lat = j;
                break;
            end
        end
        checkOutput("v42_latency", 32'(lat), 32'd14);
        checkOutput("v42_digitos", 32'(digitos), 32'({5'd0, 5'd0, 5'd4, 5'd2}));
        applyStimulus(777, {5'd0, 5'd7, 5'd7, 5'd7}, 1'b0, "v777_in_done");

        // Abort a conversion with reset: outputs drop at once and no done follows.
        start = 1'b1;
        valor = WIDTH'(5000);
        for (int j = 0; j < 7; j++) begin
            @(posedge clock); #1;
            start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_digitos", 32'(digitos), 32'd0);
        checkOutput("abort_overflow", 32'(overflow), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        applyStimulus(5, {5'd0, 5'd0, 5'd0, 5'd5}, 1'b0, "v5_after_abort");

        for (int i = 0; i < 1000; i++) begin
            int v;
            v = int'($urandom_range(0, 16383));
            applyStimulus(v, refDig(v), v > 9999, "rand");
        end

        repeat (3) @(posedge clock);
        #1;
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
